// File: rtl/srff_pkg.sv
// srff_pkg: shared types and the per-channel next-state helper for the SR
// flip-flop bank.
//   mode_e  : SR_LEVEL (requests are active-high levels) or SR_EDGE (requests
//             are rising edges of s/r)
//   prio_e  : how a channel resolves set and reset requests that are active
//             in the same cycle
//   srff_resolve : next q for one channel, given its current state and its
//             active set/reset requests
package srff_pkg;

  typedef enum logic {
    SR_LEVEL = 1'b0,
    SR_EDGE  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    PRIO_SET    = 2'd0,
    PRIO_RESET  = 2'd1,
    PRIO_HOLD   = 2'd2,
    PRIO_TOGGLE = 2'd3
  } prio_e;

  function automatic logic srff_resolve(input prio_e prio, input logic q,
                                        input logic set_act, input logic rst_act);
    logic nxt;
    nxt = q;
    if (set_act && rst_act) begin
      case (prio)
        PRIO_SET:    nxt = 1'b1;
        PRIO_RESET:  nxt = 1'b0;
        PRIO_HOLD:   nxt = q;
        PRIO_TOGGLE: nxt = ~q;
        default:     nxt = q;
      endcase
    end else if (set_act) begin
      nxt = 1'b1;
    end else if (rst_act) begin
      nxt = 1'b0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/srff_cell.sv
// srff_cell: one SR channel -- optional edge detection, conflict resolution,
// the q flop and the registered conflict flag.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset (q <= INIT, conflict <= 0)
//   s, r         : set / reset request for this channel
//   q            : registered channel state
//   conflict     : registered, high the cycle after both requests were active
//   conflict_nxt : combinational "both requests active this cycle", feeds the
//                  shared conflict counter in the bank
module srff_cell
  import srff_pkg::*;
#(
  parameter logic  INIT = 1'b1,
  parameter mode_e MODE = SR_LEVEL,
  parameter prio_e PRIO = PRIO_RESET
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic conflict,
  output logic conflict_nxt
);

  logic s_d_q, r_d_q;
  logic q_q, q_d;
  logic conf_q;
  logic set_act, rst_act;

  always_comb begin
    set_act = s;
    rst_act = r;
    if (MODE == SR_EDGE) begin
      set_act = s & ~s_d_q;
      rst_act = r & ~r_d_q;
    end
    conflict_nxt = set_act & rst_act;
    q_d          = srff_resolve(PRIO, q_q, set_act, rst_act);
  end

  // Previous-input history is loaded even during reset, so a level held high
  // across reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    s_d_q <= s;
    r_d_q <= r;
    if (rst) begin
      q_q    <= INIT;
      conf_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      conf_q <= conflict_nxt;
    end
  end

  assign q        = q_q;
  assign conflict = conf_q;

endmodule

// File: rtl/srff_bank.sv
// srff_bank: WIDTH independent SR flip-flops plus a shared saturating count
// of cycles in which any channel saw conflicting requests.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   s, r         : per-channel set / reset requests [WIDTH]
//   clr_cnt      : synchronous clear of conflict_cnt, wins over increment
//   q            : registered channel states [WIDTH]
//   conflict     : registered per-channel conflict flags [WIDTH]
//   conflict_cnt : saturating conflict-cycle count [CNT_W]
module srff_bank
  import srff_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '1,
  parameter mode_e            MODE  = SR_LEVEL,
  parameter prio_e            PRIO  = PRIO_RESET,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] conf_nxt;
  logic             any_conf;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    srff_cell #(
      .INIT (INIT[i]),
      .MODE (MODE),
      .PRIO (PRIO)
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .s            (s[i]),
      .r            (r[i]),
      .q            (q[i]),
      .conflict     (conflict[i]),
      .conflict_nxt (conf_nxt[i])
    );
  end

  // One increment per conflicting cycle, however many channels conflict.
  assign any_conf = |conf_nxt;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (any_conf && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_srff_bank.sv
module tb_srff_bank;
  import srff_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s, r;
  logic       clr_cnt;

  logic [3:0] q_rst, q_set, q_hold, q_tog, q_edge, q_edge0, q_c2;
  logic [3:0] cf_rst, cf_set, cf_hold, cf_tog, cf_edge, cf_edge0, cf_c2;
  logic [7:0] cnt_rst, cnt_set, cnt_hold, cnt_tog, cnt_edge, cnt_edge0;
  logic [1:0] cnt_c2;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  srff_bank u_rst (.clk(clk), .rst(rst), .s(s), .r(r), .clr_cnt(clr_cnt),
                   .q(q_rst), .conflict(cf_rst), .conflict_cnt(cnt_rst));
  srff_bank #(.PRIO(PRIO_SET)) u_set (.clk(clk), .rst(rst), .s(s), .r(r), .clr_cnt(clr_cnt),
                   .q(q_set), .conflict(cf_set), .conflict_cnt(cnt_set));
  srff_bank #(.PRIO(PRIO_HOLD)) u_hold (.clk(clk), .rst(rst), .s(s), .r(r), .clr_cnt(clr_cnt),
                   .q(q_hold), .conflict(cf_hold), .conflict_cnt(cnt_hold));
  srff_bank #(.PRIO(PRIO_TOGGLE)) u_tog (.clk(clk), .rst(rst), .s(s), .r(r), .clr_cnt(clr_cnt),
                   .q(q_tog), .conflict(cf_tog), .conflict_cnt(cnt_tog));
  srff_bank #(.MODE(SR_EDGE)) u_edge (.clk(clk), .rst(rst), .s(s), .r(r), .clr_cnt(clr_cnt),
                   .q(q_edge), .conflict(cf_edge), .conflict_cnt(cnt_edge));
  srff_bank #(.MODE(SR_EDGE), .INIT(4'b0000)) u_edge0 (.clk(clk), .rst(rst), .s(s), .r(r),
                   .clr_cnt(clr_cnt), .q(q_edge0), .conflict(cf_edge0), .conflict_cnt(cnt_edge0));
  srff_bank #(.CNT_W(2)) u_c2 (.clk(clk), .rst(rst), .s(s), .r(r), .clr_cnt(clr_cnt),
                   .q(q_c2), .conflict(cf_c2), .conflict_cnt(cnt_c2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_c2 [6] = '{1, 2, 3, 3, 3, 3};
    rst = 1'b1; s = '0; r = '0; clr_cnt = 1'b0;
    step();
    chk("rst_q",    32'(q_rst),   32'hF);
    chk("rst_cf",   32'(cf_rst),  32'h0);
    chk("rst_cnt",  32'(cnt_rst), 32'h0);
    chk("rst_q_e0", 32'(q_edge0), 32'h0);

    // Level mode: clear bits 0 and 2, then hold.
    rst = 1'b0; r = 4'b0101;
    step();
    chk("lvl_clr", 32'(q_rst), 32'hA);
    r = '0;
    step();
    chk("lvl_hold", 32'(q_rst), 32'hA);

    // Bring all level instances to q=0101, then conflict on bits 0,1.
    s = 4'b0101; r = 4'b1010;
    step();
    chk("lvl_0101", 32'(q_tog), 32'h5);
    s = 4'b0011; r = 4'b0011;
    step();
    chk("prio_set",   32'(q_set),   32'h7);
    chk("prio_reset", 32'(q_rst),   32'h4);
    chk("prio_hold",  32'(q_hold),  32'h5);
    chk("prio_tog",   32'(q_tog),   32'h6);
    chk("conf_flag",  32'(cf_rst),  32'h3);
    chk("conf_flag_t",32'(cf_tog),  32'h3);
    chk("conf_cnt",   32'(cnt_rst), 32'h1);
    chk("conf_cnt_h", 32'(cnt_hold),32'h1);
    s = '0; r = '0;
    step();
    chk("conf_drop", 32'(cf_rst),  32'h0);
    chk("cnt_keep",  32'(cnt_rst), 32'h1);
    chk("tog_hold",  32'(q_tog),   32'h6);

    // Edge mode: held reset clears once; a later set edge restores.
    rst = 1'b1; s = '0; r = '0;
    step();
    rst = 1'b0; r = 4'b0001;
    step();
    chk("edge_clr", 32'(q_edge), 32'hE);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("edge_rheld", 32'(q_edge), 32'hE);
    end
    s = 4'b0001;
    step();
    chk("edge_set", 32'(q_edge), 32'hF);
    chk("edge_nocf", 32'(cf_edge), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("edge_noreclr", 32'(q_edge), 32'hF);
    end
    s = '0;
    step();
    chk("edge_fall", 32'(q_edge), 32'hF);

    // Edge mode: set level held across reset release is not an edge.
    rst = 1'b1; s = 4'b1111; r = '0;
    step();
    chk("e0_rst", 32'(q_edge0), 32'h0);
    rst = 1'b0;
    step();
    chk("e0_noedge1", 32'(q_edge0), 32'h0);
    step();
    chk("e0_noedge2", 32'(q_edge0), 32'h0);

    // Saturating 2-bit counter under continuous conflicts.
    rst = 1'b1; s = '0; r = '0;
    step();
    rst = 1'b0; s = 4'b1111; r = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("c2_sat", 32'(cnt_c2), 32'(exp_c2[i]));
    end
    chk("c2_cf", 32'(cf_c2), 32'hF);
    clr_cnt = 1'b1;
    step();
    chk("c2_clr", 32'(cnt_c2), 32'h0);
    clr_cnt = 1'b0;
    step();
    chk("c2_after", 32'(cnt_c2), 32'h1);

    // Reset wins over a same-cycle request.
    s = 4'b0000; r = 4'b1111;
    step();
    chk("pre_rst_q", 32'(q_rst), 32'h0);
    rst = 1'b1; s = 4'b1111; r = '0;
    step();
    chk("ovr_q",     32'(q_rst),   32'hF);
    chk("ovr_cf",    32'(cf_rst),  32'h0);
    chk("ovr_cnt",   32'(cnt_rst), 32'h0);
    chk("ovr_q_e0",  32'(q_edge0), 32'h0);
    chk("ovr_cnt2",  32'(cnt_c2),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
